alu_share_arb: RTL and testbench
================================

# alu_share_arb

Round-robin arbiter and sequencer that shares one combinational `alu` instance between two requesters, e.g. the main datapath and a multi-cycle helper such as a mul/div or trap unit. It owns the ALU's operand and opcode inputs. It registers each granted request's operands, captures the ALU result one cycle later, and holds that result for the granted requester until the requester accepts it. Only one operation is in flight at a time.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: operand and result width; must match the shared `alu`.

Ports:
- `clk`  in  1  clock. One clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  2  per requester: request present; bit 0 = requester 0.
- `req_ready`  out  2  per requester: request accepted this cycle. At most one bit is high.
- `req_a0`, `req_b0`  in  DATA_WIDTH each  requester 0 operands.
- `req_op0`  in  4  requester 0 `alu_op`.
- `req_a1`, `req_b1`, `req_op1`: same as above, for requester 1.
- `rsp_valid`  out  2  per requester: result available. At most one bit is high.
- `rsp_ready`  in  2  per requester: result consumed.
- `rsp_data`  out  DATA_WIDTH  captured `alu_out`.
- `rsp_less`, `rsp_overflow`, `rsp_zero`  out  1 each  captured ALU flags.
- `alu_a`, `alu_b`  out  DATA_WIDTH each  to the ALU's `a_in` and `b_in`.
- `alu_op`  out  4  to the ALU's `alu_op`.
- `alu_out`  in  DATA_WIDTH  from the ALU.
- `alu_less`, `alu_overflow`, `alu_zero`  in  1 each  from the ALU.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Registers:
  - `owner` (1 bit)
  - `last` (1 bit, last granted requester)
  - operand register {a, b, op}
  - result register {data, less, overflow, zero}
- Grant (combinational, IDLE only):
  - If only one `req_valid` bit is set, that requester wins.
  - If both are set, the winner is `~last`.
  - `req_ready[winner]` = 1 in IDLE only. It is 0 in EXEC and RESP.
- IDLE:
  - On handshake (`req_valid[w] & req_ready[w]`), latch that requester's a/b/op.
  - Set `owner = w` and `last = w`, then go to EXEC.
  - With no request, stay in IDLE.
- EXEC (exactly 1 cycle):
  - `alu_a`, `alu_b`, `alu_op` are driven from the operand register.
  - At the end of the cycle, capture `alu_out` and all three flags into the result register, then go to RESP.
- RESP:
  - `rsp_valid[owner]` = 1, and the `rsp_*` outputs show the result register.
  - Stay in RESP while `rsp_ready[owner]` = 0.
  - On `rsp_ready[owner]` = 1, go to IDLE.
  - `rsp_ready` of the non-owner is ignored.
- ALU drive:
  - `alu_a`, `alu_b` and `alu_op` always reflect the operand register, in every state.
  - The ALU output is sampled only at the end of EXEC.
- Requester rule: once `req_valid` is raised, the requester holds it and its operands stable until `req_ready`. The arbiter itself only samples on a handshake.
- Opcodes pass through unmodified. Overflow/less/zero semantics are the ALU's, e.g. op 0 = addu (overflow forced 0) and op 15 = sub (overflow reported).
- Width rule: no extension or truncation. All data paths are `DATA_WIDTH` bits.

## Timing
- Reset (`rst` = 1 at an edge), all values after that edge:
  - State = IDLE; `owner` = 0; `last` = 1, so requester 0 wins the first tie.
  - Operand register = 0, so `alu_a` = `alu_b` = 0 and `alu_op` = 0.
  - Result register = 0.
  - `rsp_valid` = 00 and `busy` = 0.
  - `req_ready` follows the grant rule combinationally.
- Reset mid-operation (in EXEC or RESP): the in-flight result is discarded and no `rsp_valid` is produced for it. The next cycle is IDLE.
- Latency: handshake in cycle T, EXEC in T+1, `rsp_valid` high from T+2.
- Throughput: with `rsp_ready` held high, one operation every 3 cycles. The next grant can occur in the cycle after the RESP handshake.
- Simultaneous requests alternate strictly, e.g. 0,1,0,1 with both held high.
- A request that arrives while the arbiter is busy waits in IDLE arbitration. Its priority is fixed by `last`, not by arrival order.
- A `rsp_ready` already high on entry to RESP completes the response in that first RESP cycle, so `rsp_valid` is high for exactly 1 cycle.
- `rsp_data` and the flags are stable for the whole time `rsp_valid` is high.

## Test plan
- Reset, then requester 0 only, op 0, a=5, b=7, `rsp_ready[0]` held 1:
  - `req_ready` = 01 in cycle T.
  - In cycle T+2: `rsp_valid` = 01, `rsp_data` = 12, `rsp_overflow` = 0.
  - IDLE in T+3.
- Requester 1, op 15, a=0x80000000, b=1: `rsp_data` = 0x7FFFFFFF, `rsp_overflow` = 1, `rsp_valid` = 10.
- Both requesters held valid from reset, ops 0 and 1 with distinct operands: grants are 0,1,0,1. Each result is routed only to its owner, and no `rsp_valid` overlap occurs.
- Owner holds `rsp_ready` = 0 for 5 cycles while the other requester is valid:
  - State stays RESP, `rsp_data` is unchanged and `req_ready` = 00.
  - After release, the other requester is granted next.
- `rst` pulsed during EXEC: no `rsp_valid` ever appears for that op; `busy` = 0 and `alu_op` = 0 after the edge.
- Op 14 (add) with a=0x7FFFFFFF, b=1: `rsp_data` = 0x80000000, `rsp_overflow` = 1, `rsp_less` = 0.

Source files
------------

// File: rtl/alu_share_arb_if.sv
// Requester-side bundle for alu_share_arb: two request channels and the shared response path.
interface alu_share_arb_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [DATA_WIDTH-1:0] req_a0;
  logic [DATA_WIDTH-1:0] req_b0;
  logic [3:0]            req_op0;
  logic [DATA_WIDTH-1:0] req_a1;
  logic [DATA_WIDTH-1:0] req_b1;
  logic [3:0]            req_op1;
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_less;
  logic                  rsp_overflow;
  logic                  rsp_zero;

  // Requester side (both requesters share one bundle).
  modport master (
    output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_less, rsp_overflow, rsp_zero
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_less, rsp_overflow, rsp_zero
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight: IDLE grants, EXEC drives the ALU, RESP holds the result.
module alu_share_arb #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_share_arb_if.slave        bus,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_less,
  input  logic                  alu_overflow,
  input  logic                  alu_zero,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [3:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  res_less_q, res_less_d;
  logic                  res_ovf_q, res_ovf_d;
  logic                  res_zero_q, res_zero_d;

  logic win;
  logic any_req;
  logic is_idle;

  // Grant selection: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    win = 1'b0;
    unique case (bus.req_valid)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_q;
      default: win = 1'b0;
    endcase
  end

  assign any_req = |bus.req_valid;
  assign is_idle = (state_q == StIdle);

  assign bus.req_ready[0] = is_idle & any_req & ~win;
  assign bus.req_ready[1] = is_idle & any_req & win;

  assign bus.rsp_valid[0] = (state_q == StResp) & ~owner_q;
  assign bus.rsp_valid[1] = (state_q == StResp) & owner_q;
  assign bus.rsp_data     = res_data_q;
  assign bus.rsp_less     = res_less_q;
  assign bus.rsp_overflow = res_ovf_q;
  assign bus.rsp_zero     = res_zero_q;

  // ALU inputs always mirror the operand register, so they are quiet outside EXEC too.
  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;
  assign busy   = ~is_idle;

  // Next-state logic: grant and latch operands, capture the ALU, release on response accept.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_data_d = res_data_q;
    res_less_d = res_less_q;
    res_ovf_d  = res_ovf_q;
    res_zero_d = res_zero_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          a_d     = win ? bus.req_a1  : bus.req_a0;
          b_d     = win ? bus.req_b1  : bus.req_b0;
          op_d    = win ? bus.req_op1 : bus.req_op0;
          owner_d = win;
          last_d  = win;
          state_d = StExec;
        end
      end
      StExec: begin
        res_data_d = alu_out;
        res_less_d = alu_less;
        res_ovf_d  = alu_overflow;
        res_zero_d = alu_zero;
        state_d    = StResp;
      end
      StResp: begin
        // Only the owner's rsp_ready matters.
        if (bus.rsp_ready[owner_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_data_q <= '0;
      res_less_q <= 1'b0;
      res_ovf_q  <= 1'b0;
      res_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      res_data_q <= res_data_d;
      res_less_q <= res_less_d;
      res_ovf_q  <= res_ovf_d;
      res_zero_q <= res_zero_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: directed scenarios then randomized traffic.
module tb_alu_share_arb;
  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] data;
    logic         less;
    logic         ovf;
    logic         zero;
  } res_t;

  typedef struct {
    int   owner;
    int   gcyc;
    res_t r;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [3:0]   alu_op;
  logic         alu_less, alu_overflow, alu_zero;
  logic         busy;
  res_t         alu_r;

  alu_share_arb_if #(.DATA_WIDTH(W)) bus ();

  alu_share_arb #(.DATA_WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_out      (alu_out),
    .alu_less     (alu_less),
    .alu_overflow (alu_overflow),
    .alu_zero     (alu_zero),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; ops 0/1 unsigned (no overflow), 14/15 signed add/sub with overflow.
  function automatic res_t alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] op);
    res_t r;
    r = '0;
    case (op)
      4'd0:  r.data = a + b;
      4'd1:  r.data = a - b;
      4'd2:  r.data = a & b;
      4'd3:  r.data = a | b;
      4'd4:  r.data = a ^ b;
      4'd14: begin
        r.data = a + b;
        r.ovf  = (a[W-1] == b[W-1]) && (r.data[W-1] != a[W-1]);
      end
      4'd15: begin
        r.data = a - b;
        r.ovf  = (a[W-1] != b[W-1]) && (r.data[W-1] != a[W-1]);
      end
      default: r.data = ~(a | b);
    endcase
    r.less = $signed(a) < $signed(b);
    r.zero = (r.data == '0);
    return r;
  endfunction

  assign alu_r        = alu_f(alu_a, alu_b, alu_op);
  assign alu_out      = alu_r.data;
  assign alu_less     = alu_r.less;
  assign alu_overflow = alu_r.ovf;
  assign alu_zero     = alu_r.zero;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  ent_t sb[$];
  int   gorder[$];
  logic m_last   = 1'b1;
  logic post_rst = 1'b0;
  logic [1:0] hs = 2'b00;
  logic [3:0] op_tab [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd14, 4'd15};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] op);
    if (r == 0) begin
      bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op;
    end else begin
      bus.req_a1 = a; bus.req_b1 = b; bus.req_op1 = op;
    end
  endtask

  task automatic set_rand(input int r);
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = $urandom;
    b = ($urandom_range(3) == 0) ? a : $urandom;
    set_req(r, a, b, op_tab[$urandom_range(7)]);
  endtask

  task automatic issue(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] op);
    set_req(r, a, b, op);
    bus.req_valid[r] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (hs[r]) break;
    end
    chk("issue_handshake", {63'd0, hs[r]}, 64'd1);
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
  endtask

  // Monitor: cycle-level model of grant, busy and response timing, plus result scoreboard.
  task automatic monitor();
    logic [1:0] exp_rr;
    logic [1:0] exp_rv;
    logic       w;
    logic       was_empty;
    ent_t       e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        sb.delete();
        m_last   = 1'b1;
        post_rst = 1'b1;
        hs       = 2'b00;
      end else begin
        if (post_rst) begin
          chk("rst_busy", {63'd0, busy}, 64'd0);
          chk("rst_alu_a", {32'd0, alu_a}, 64'd0);
          chk("rst_alu_b", {32'd0, alu_b}, 64'd0);
          chk("rst_alu_op", {60'd0, alu_op}, 64'd0);
          chk("rst_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
          post_rst = 1'b0;
        end
        was_empty = (sb.size() == 0);
        exp_rr = 2'b00;
        w = 1'b0;
        if (was_empty && bus.req_valid != 2'b00) begin
          w = (bus.req_valid == 2'b11) ? ~m_last : bus.req_valid[1];
          exp_rr[w] = 1'b1;
        end
        chk("req_ready", {62'd0, bus.req_ready}, {62'd0, exp_rr});
        chk("busy", {63'd0, busy}, {63'd0, !was_empty});
        exp_rv = 2'b00;
        if (!was_empty && cyc >= sb[0].gcyc + 2) exp_rv[sb[0].owner] = 1'b1;
        chk("rsp_valid", {62'd0, bus.rsp_valid}, {62'd0, exp_rv});
        if (exp_rv != 2'b00) begin
          chk("rsp_data", {32'd0, bus.rsp_data}, {32'd0, sb[0].r.data});
          chk("rsp_less", {63'd0, bus.rsp_less}, {63'd0, sb[0].r.less});
          chk("rsp_overflow", {63'd0, bus.rsp_overflow}, {63'd0, sb[0].r.ovf});
          chk("rsp_zero", {63'd0, bus.rsp_zero}, {63'd0, sb[0].r.zero});
          if (bus.rsp_ready[sb[0].owner]) void'(sb.pop_front());
        end
        if (exp_rr != 2'b00) begin
          e.owner = int'(w);
          e.gcyc  = cyc;
          e.r     = w ? alu_f(bus.req_a1, bus.req_b1, bus.req_op1)
                      : alu_f(bus.req_a0, bus.req_b0, bus.req_op0);
          sb.push_back(e);
          m_last = w;
        end
        hs = bus.req_valid & bus.req_ready;
        if (hs == 2'b01) gorder.push_back(0);
        if (hs == 2'b10) gorder.push_back(1);
      end
    end
  endtask

  task automatic driver();
    int o;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    set_req(0, '0, '0, 4'd0);
    set_req(1, '0, '0, 4'd0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single requests, including overflow corner cases.
    bus.rsp_ready = 2'b11;
    issue(0, 32'd5, 32'd7, 4'd0);
    wait_idle();
    issue(1, 32'h8000_0000, 32'd1, 4'd15);
    wait_idle();
    issue(0, 32'h7FFF_FFFF, 32'd1, 4'd14);
    wait_idle();

    // Both requesters held valid from reset: strict alternation expected.
    rst = 1'b1;
    set_req(0, 32'd100, 32'd3, 4'd0);
    set_req(1, 32'd50, 32'd9, 4'd1);
    bus.req_valid = 2'b11;
    tick();
    gorder.delete();
    rst = 1'b0;
    for (int i = 0; i < 60 && gorder.size() < 4; i++) begin
      tick();
      for (int r = 0; r < 2; r++) if (hs[r]) set_rand(r);
    end
    bus.req_valid = 2'b00;
    chk("alt_count", 64'(gorder.size() >= 4), 64'd1);
    for (int i = 0; i < 4 && i < gorder.size(); i++) chk("alt_order", 64'(gorder[i]), 64'(i % 2));
    wait_idle();

    // Owner stalls the response while the other requester waits.
    bus.rsp_ready = 2'b00;
    set_rand(0);
    set_rand(1);
    bus.req_valid = 2'b11;
    gorder.delete();
    for (int i = 0; i < 20 && hs == 2'b00; i++) tick();
    o = hs[1] ? 1 : 0;
    bus.req_valid[o] = 1'b0;
    repeat (7) tick();
    bus.rsp_ready = 2'b11;
    for (int i = 0; i < 20 && !hs[1-o]; i++) tick();
    bus.req_valid = 2'b00;
    chk("stall_grant_count", 64'(gorder.size()), 64'd2);
    if (gorder.size() == 2) chk("stall_next_grant", 64'(gorder[1]), 64'(1 - o));
    wait_idle();

    // Reset while the operation is in EXEC: its result must never appear.
    issue(0, 32'h1234, 32'h0FF0, 4'd15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (6) tick();

    // Randomized traffic with random response back-pressure.
    for (int c = 0; c < 2000; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (bus.req_valid[r] && hs[r]) bus.req_valid[r] = 1'b0;
        if (!bus.req_valid[r] && $urandom_range(2) == 0) begin
          set_rand(r);
          bus.req_valid[r] = 1'b1;
        end
      end
      bus.rsp_ready = 2'($urandom);
      tick();
    end
    for (int i = 0; i < 40 && bus.req_valid != 2'b00; i++) begin
      for (int r = 0; r < 2; r++) if (hs[r]) bus.req_valid[r] = 1'b0;
      tick();
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    wait_idle();
    chk("drain_empty", 64'(sb.size()), 64'd0);
    repeat (2) tick();
  endtask

  initial begin
    fork
      monitor();
      driver();
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
